// File: rtl/cpu_pkg.sv
// Shared datapath constants: word width, input-port depth and the BusMux source encoding.
// Imported by the InPort block and the Datapath bus multiplexer.
package cpu_pkg;

    localparam int WORD_W       = 32;
    localparam int INPORT_DEPTH = 2;

    typedef enum logic [2:0] {
        BUS_SEL_REG    = 3'd0,
        BUS_SEL_HI     = 3'd1,
        BUS_SEL_LO     = 3'd2,
        BUS_SEL_ZHI    = 3'd3,
        BUS_SEL_ZLO    = 3'd4,
        BUS_SEL_PC     = 3'd5,
        BUS_SEL_MDR    = 3'd6,
        BUS_SEL_INPORT = 3'd7
    } bus_sel_t;

    localparam bus_sel_t INPORT_BUS_SEL = BUS_SEL_INPORT;

endpackage

// File: rtl/inport_unit_if.sv
// Bundle between the external producer/datapath (master) and the InPort block (slave).
interface inport_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic             In_out;
    logic [WIDTH-1:0] In_data_out;
    logic             in_avail;
    logic             in_underrun;
    logic             err_clr;

    modport master (
        output ext_data, ext_valid, In_out, err_clr,
        input  ext_ready, In_data_out, in_avail, in_underrun
    );

    modport slave (
        input  ext_data, ext_valid, In_out, err_clr,
        output ext_ready, In_data_out, in_avail, in_underrun
    );

endinterface

// File: rtl/inport_fifo.sv
// Circular word buffer with push/pop/full/empty; the head is readable combinationally.
// Push and pop take effect on the clock edge; a push while full or a pop while empty is ignored.
module inport_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = INPORT_DEPTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdat,
    output logic [WIDTH-1:0] o_rdat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdat    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: only entries covered by r_count are ever observed.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdat;
    end

endmodule

// File: rtl/inport_unit.sv
// InPort peripheral: external valid/ready pushes into a FIFO, one pop per rising In_out strobe.
// Head shows combinationally in the first strobe cycle; ext_ready is low whenever the FIFO is full.
module inport_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = INPORT_DEPTH
) (
    input  logic          clk,
    input  logic          clr,
    inport_unit_if.slave  bus
);
    logic [WIDTH-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_rise;
    logic             w_push;
    logic             w_pop;
    logic             r_in_out_d;
    logic [WIDTH-1:0] r_hold_q;
    logic             r_underrun;

    assign w_rise = bus.In_out & ~r_in_out_d;
    assign w_push = bus.ext_valid & ~w_full;
    assign w_pop  = w_rise & ~w_empty;

    inport_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdat  (bus.ext_data),
        .o_rdat  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_in_out_d <= 1'b0;
            r_hold_q   <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_in_out_d <= bus.In_out;
            if (w_pop) r_hold_q <= w_head;
            // A fresh underrun outranks a coincident clear.
            if (w_rise & w_empty)  r_underrun <= 1'b1;
            else if (bus.err_clr)  r_underrun <= 1'b0;
        end
    end

    // While a strobe is held the bus keeps the popped word rather than the next entry.
    assign bus.In_data_out = (~r_in_out_d & ~w_empty) ? w_head : r_hold_q;
    assign bus.ext_ready   = ~w_full;
    assign bus.in_avail    = ~w_empty;
    assign bus.in_underrun = r_underrun;

endmodule

// File: tb/tb_inport_unit.sv
// Directed bench for inport_unit: per-cycle vector table plus wrap and reset sequences.
module tb_inport_unit;
    import cpu_pkg::*;

    logic clk;
    logic clr;

    inport_unit_if #(.WIDTH(32)) bus ();

    inport_unit #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        io;
        logic        ec;
        logic        e_rdy;
        logic        e_av;
        logic [31:0] e_dat;
        logic        e_und;
    } vec_t;

    vec_t vt [40];
    int   nv;
    int   n_vec;
    int   n_err;

    task automatic add(input logic v, input logic [31:0] d, input logic io, input logic ec,
                       input logic e_rdy, input logic e_av, input logic [31:0] e_dat,
                       input logic e_und);
        vt[nv] = '{v, d, io, ec, e_rdy, e_av, e_dat, e_und};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic io, input logic ec);
        bus.ext_valid = v;
        bus.ext_data  = d;
        bus.In_out    = io;
        bus.err_clr   = ec;
    endtask

    initial begin
        logic [31:0] wa;
        logic [31:0] wb;
        n_vec = 0;
        n_err = 0;
        nv    = 0;

        //   v  data          io ec  rdy av  data          und
        add(1, 32'h11111111, 0, 0,  1, 0, 32'h00000000, 0); // first push
        add(1, 32'h22222222, 0, 0,  1, 1, 32'h11111111, 0); // push latency: head visible
        add(1, 32'h33333333, 0, 0,  0, 1, 32'h11111111, 0); // full, stalled
        add(1, 32'h33333333, 1, 0,  0, 1, 32'h11111111, 0); // pop cycle, no bypass push
        add(1, 32'h33333333, 0, 0,  1, 1, 32'h11111111, 0); // 0x33 accepted here
        add(0, 32'h0,        0, 0,  0, 1, 32'h22222222, 0);
        add(0, 32'h0,        1, 0,  0, 1, 32'h22222222, 0); // held strobe, 3 cycles
        add(0, 32'h0,        1, 0,  1, 1, 32'h22222222, 0);
        add(0, 32'h0,        1, 0,  1, 1, 32'h22222222, 0);
        add(0, 32'h0,        0, 0,  1, 1, 32'h22222222, 0);
        add(0, 32'h0,        0, 0,  1, 1, 32'h33333333, 0); // only one pop happened
        add(0, 32'h0,        1, 0,  1, 1, 32'h33333333, 0);
        add(0, 32'h0,        0, 0,  1, 0, 32'h33333333, 0);
        add(0, 32'h0,        1, 0,  1, 0, 32'h33333333, 0); // underrun read
        add(0, 32'h0,        0, 0,  1, 0, 32'h33333333, 1);
        add(0, 32'h0,        0, 1,  1, 0, 32'h33333333, 1); // err_clr
        add(0, 32'h0,        0, 0,  1, 0, 32'h33333333, 0);
        add(0, 32'h0,        1, 1,  1, 0, 32'h33333333, 0); // set beats clear
        add(0, 32'h0,        0, 0,  1, 0, 32'h33333333, 1);
        add(0, 32'h0,        0, 1,  1, 0, 32'h33333333, 1);
        add(1, 32'h44444444, 0, 0,  1, 0, 32'h33333333, 0);
        add(1, 32'h55555555, 1, 0,  1, 1, 32'h44444444, 0); // push+pop at count 1
        add(0, 32'h0,        0, 0,  1, 1, 32'h44444444, 0);
        add(0, 32'h0,        0, 0,  1, 1, 32'h55555555, 0); // count still 1
        add(0, 32'h0,        1, 0,  1, 1, 32'h55555555, 0);
        add(0, 32'h0,        0, 0,  1, 0, 32'h55555555, 0);

        drive(0, 32'h0, 0, 0);
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ext_ready",   {31'd0, bus.ext_ready},   32'd1);
        chk("reset in_avail",    {31'd0, bus.in_avail},    32'd0);
        chk("reset In_data_out", bus.In_data_out,          32'd0);
        chk("reset in_underrun", {31'd0, bus.in_underrun}, 32'd0);
        clr = 1'b0;

        for (int i = 0; i < nv; i++) begin
            drive(vt[i].v, vt[i].d, vt[i].io, vt[i].ec);
            @(negedge clk);
            chk($sformatf("v%0d ext_ready", i),   {31'd0, bus.ext_ready},   {31'd0, vt[i].e_rdy});
            chk($sformatf("v%0d in_avail", i),    {31'd0, bus.in_avail},    {31'd0, vt[i].e_av});
            chk($sformatf("v%0d In_data_out", i), bus.In_data_out,          vt[i].e_dat);
            chk($sformatf("v%0d in_underrun", i), {31'd0, bus.in_underrun}, {31'd0, vt[i].e_und});
            @(posedge clk);
            #1;
        end

        // Wrap: 0xA0..0xA7 in pairs, each pair drained by high/low/high strobes.
        for (int k = 0; k < 4; k++) begin
            wa = 32'hA0 + 32'(2 * k);
            wb = wa + 32'd1;
            drive(1, wa, 0, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d rdy0", k), {31'd0, bus.ext_ready}, 32'd1);
            @(posedge clk); #1;
            drive(1, wb, 0, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d head", k), bus.In_data_out, wa);
            @(posedge clk); #1;
            drive(0, 32'h0, 1, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d full", k), {31'd0, bus.ext_ready}, 32'd0);
            chk($sformatf("wrap%0d rd0", k), bus.In_data_out, wa);
            @(posedge clk); #1;
            drive(0, 32'h0, 0, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d hold0", k), bus.In_data_out, wa);
            @(posedge clk); #1;
            drive(0, 32'h0, 1, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d rd1", k), bus.In_data_out, wb);
            @(posedge clk); #1;
            drive(0, 32'h0, 0, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d empty", k), {31'd0, bus.in_avail}, 32'd0);
            chk($sformatf("wrap%0d hold1", k), bus.In_data_out, wb);
            @(posedge clk); #1;
        end

        // Mid-stream reset with an underrun pending, FIFO full and strobe high.
        drive(0, 32'h0, 1, 0);
        @(posedge clk); #1;
        drive(1, 32'hCAFE0001, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'hCAFE0002, 0, 0);
        @(posedge clk); #1;
        drive(0, 32'h0, 0, 0);
        @(negedge clk);
        chk("pre-reset full",     {31'd0, bus.ext_ready},   32'd0);
        chk("pre-reset underrun", {31'd0, bus.in_underrun}, 32'd1);
        @(posedge clk); #1;
        drive(0, 32'h0, 1, 0);
        clr = 1'b1;
        #2;
        chk("midreset ext_ready",   {31'd0, bus.ext_ready},   32'd1);
        chk("midreset in_avail",    {31'd0, bus.in_avail},    32'd0);
        chk("midreset In_data_out", bus.In_data_out,          32'd0);
        chk("midreset in_underrun", {31'd0, bus.in_underrun}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("post-reset rise underrun", {31'd0, bus.in_underrun}, 32'd1);
        chk("post-reset In_data_out",   bus.In_data_out,          32'd0);
        drive(0, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inport_unit.md
# inport_unit

Input-port peripheral for the datapath: the producer-side counterpart to the Out port register. An external device pushes 32-bit words over a valid/ready handshake into a small FIFO. The datapath consumes one word per `in` instruction by asserting `In_out`, and the block drives `In_data_out` into the bus multiplexer's InPort input. The block also provides word-available and underrun status for the control unit.

## Interface
Parameters:
- `WIDTH`, default 32: data word width.
- `DEPTH`, default 2: FIFO entries, power of two, at least 2.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `clr`, in, 1: asynchronous, active-high reset.
- `ext_data`, in, WIDTH: word from the external device.
- `ext_valid`, in, 1: the external device presents `ext_data`.
- `ext_ready`, out, 1: block can accept a word this cycle.
- `In_out`, in, 1: datapath read strobe (level; may be held for several cycles).
- `In_data_out`, out, WIDTH: word driven to the BusMux InPort input.
- `in_avail`, out, 1: FIFO is non-empty.
- `in_underrun`, out, 1: sticky flag; a read was attempted while the FIFO was empty.
- `err_clr`, in, 1: synchronous clear of `in_underrun`.

## Operation
- **Storage:** circular buffer of DEPTH entries with `wr_ptr`, `rd_ptr` (log2(DEPTH) bits, wrap naturally) and `count` (0..DEPTH).
- **Readiness:** `ext_ready = (count != DEPTH)`, combinational from registered `count`. There is no bypass, so a full FIFO refuses a word even in a cycle that pops.
- **Push:** `ext_valid & ext_ready` at the clock edge. `ext_data` is written at `wr_ptr`, then `wr_ptr` is incremented.
- **Read-edge detect:** register `in_out_d <= In_out`; `rise = In_out & ~in_out_d`. Exactly one pop attempt is made per `In_out` assertion, however long the strobe is held.
- **Pop:** `rise & (count != 0)`. At the edge, `hold_q <= mem[rd_ptr]` and `rd_ptr` is incremented.
- **Underrun:** `rise & (count == 0)` sets `in_underrun`. `hold_q` and the pointers are unchanged.
- **Underrun clear:** `err_clr` clears `in_underrun`. If `err_clr` coincides with a new underrun event, the set wins.
- **Count update:** `count` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- **Output select:**
  - `In_data_out = mem[rd_ptr]` when `~in_out_d & (count != 0)`.
  - `In_data_out = hold_q` otherwise.
  - Consequence: during a multi-cycle strobe the bus stays at the popped word, not the next entry.
- `in_avail = (count != 0)`.

## Timing
- **Reset values (while `clr` is asserted):** `count`, pointers, `hold_q`, `in_out_d` and `in_underrun` are 0. Therefore `ext_ready=1`, `in_avail=0` and `In_data_out=0`.
- **Reset mid-operation:** drops buffered data and any in-flight strobe. No pop is attempted on the first edge after release unless `In_out` is high at that edge; a high `In_out` after release counts as a rise because `in_out_d` was reset.
- **Push latency:** a word pushed at edge N is visible on `In_data_out`, with `in_avail=1`, after edge N, provided no earlier words are queued.
- **Read cycle:** the first `In_out` cycle shows the head combinationally, and the word is latched into the bus register within that cycle. The pop takes effect at the end of that cycle.
- **Back-to-back reads:** `In_out` high, low, high on consecutive cycles gives two pops.
- **Pointer wrap:** the pointers wrap from DEPTH−1 to 0 with no bubble.
- **Full boundary:** at count = DEPTH, `ext_ready` drops on the same edge that fills the last entry.

## Structure
- **Shared package `cpu_pkg`:**
  - `WORD_W = 32`.
  - `INPORT_DEPTH = 2`.
  - BusMux select encoding constant for InPort, shared with the Datapath mux.
- **Sub-module `inport_fifo`:** storage, pointers and count, with push/pop/full/empty ports.
- **Top level:** handshake, edge detect, `hold_q`, underrun and output select.

## Test plan
- **Reset:** assert `clr` mid-stream with count=2 → `ext_ready=1`, `in_avail=0`, `In_data_out=0`, `in_underrun=0`.
- **Fill and stall:** push `0x11111111`, then `0x22222222` → `ext_ready=0`. Hold `ext_valid` with `0x33333333` → not accepted. One `In_out` pulse → `In_data_out=0x11111111` during the pulse, then `0x22222222`, and `0x33333333` is accepted the next cycle.
- **Held strobe:** `In_out` held 3 cycles with queued words A, B → `In_data_out=A` for all 3 cycles, exactly one pop, and `count` goes from 2 to 1.
- **Underrun:** empty FIFO plus an `In_out` pulse → `in_underrun=1`, and `In_data_out` keeps the last popped value. Pulse `err_clr` → `in_underrun=0`.
- **Simultaneous push and pop at count=1:** `count` stays 1, `rd_ptr` and `wr_ptr` both advance, and order is preserved.
- **Wrap:** stream 8 words (`0xA0` to `0xA7`) with reads interleaved → the words are read in order across several pointer wraps with no loss or duplication.
